// File: rtl/id_gen.sv
// id_gen: ASCII identifier stream generator (letters then digits); optional SEP state via ID_GEN_SEPARATOR_EN
module id_gen #(
  parameter int LEN_W = 4,
  parameter bit UPPER = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] alpha_len,
  input  logic [LEN_W-1:0] digit_len,
  input  logic [4:0]       alpha_base,
  input  logic [3:0]       digit_base,
  input  logic             ready,
  output logic [7:0]       char,
  output logic             valid,
  output logic             busy,
  output logic             done
);
`ifdef ID_GEN_SEPARATOR_EN
  typedef enum logic [2:0] {IDLE, ALPHA, DIGIT, SEP, FIN} state_t;
  localparam state_t TAIL = SEP;
`else
  typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, FIN} state_t;
  localparam state_t TAIL = FIN;
`endif
  localparam logic [7:0] LBASE = UPPER ? 8'd65 : 8'd97;
  state_t state, ns;
  logic [LEN_W-1:0] alen, dlen, cnt, n_alen, n_dlen, n_cnt, cnt_inc;
  logic [4:0] idx, n_idx;
  logic [3:0] d, n_d;
  logic [7:0] n_char;
  logic n_valid, n_done, xfer;
  // next state, latched run parameters, counters and the registered output values
  always_comb begin
    ns = state;
    n_alen = alen;
    n_dlen = dlen;
    n_idx = idx;
    n_d = d;
    n_cnt = cnt;
    xfer = valid && ready;
    cnt_inc = cnt + LEN_W'(1);
    case (state)
      IDLE: if (start) begin
        n_alen = alpha_len == '0 ? LEN_W'(1) : alpha_len;
        n_dlen = digit_len;
        n_idx = alpha_base > 5'd25 ? 5'd0 : alpha_base;
        n_d = digit_base > 4'd9 ? 4'd0 : digit_base;
        n_cnt = '0;
        ns = ALPHA;
      end
      ALPHA: if (xfer) begin
        n_idx = idx == 5'd25 ? 5'd0 : idx + 5'd1;
        n_cnt = cnt_inc == alen ? '0 : cnt_inc;
        ns = cnt_inc != alen ? ALPHA : dlen != '0 ? DIGIT : TAIL;
      end
      DIGIT: if (xfer) begin
        n_d = d == 4'd9 ? 4'd0 : d + 4'd1;
        n_cnt = cnt_inc == dlen ? '0 : cnt_inc;
        ns = cnt_inc != dlen ? DIGIT : TAIL;
      end
`ifdef ID_GEN_SEPARATOR_EN
      SEP: if (xfer) ns = FIN;
`endif
      FIN: ns = IDLE;
      default: ns = IDLE;
    endcase
    n_valid = ns == ALPHA || ns == DIGIT;
    n_char = ns == ALPHA ? LBASE + {3'b0, n_idx} : ns == DIGIT ? 8'd48 + {4'b0, n_d} : 8'd0;
`ifdef ID_GEN_SEPARATOR_EN
    n_valid = n_valid || ns == SEP;
    n_char = ns == SEP ? 8'd32 : n_char;
`endif
    n_done = ns == FIN;
  end
  // state, counters and outputs registered; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      alen <= '0;
      dlen <= '0;
      cnt <= '0;
      idx <= '0;
      d <= '0;
      char <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= ns;
      alen <= n_alen;
      dlen <= n_dlen;
      cnt <= n_cnt;
      idx <= n_idx;
      d <= n_d;
      char <= n_char;
      valid <= n_valid;
      busy <= n_valid;
      done <= n_done;
    end
  end
endmodule
